flex_counter_mc: RTL
====================

Name: flex_counter_mc

Overview:
Multi-channel flexible counter with controlled rollover, per-channel load, and per-channel wrap/one-shot mode. It is the parametrised successor to the team's single-channel flex counter. It serves the I2C slave (bit, byte and timeout counting) and other APB peripherals that need several independent counters without instantiating one module per counter. Channels share only clk and n_rst; each has its own controls, rollover value and flag.

Parameters:
NUM_CNT_BITS, 4, width of each channel's count, rollover and load values (>=2)
NUM_CH, 2, number of independent counter channels (>=1)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
clear  input  NUM_CH  per-channel synchronous clear
load  input  NUM_CH  per-channel synchronous load of load_val
count_enable  input  NUM_CH  per-channel increment request
one_shot  input  NUM_CH  per-channel mode: 0 = wrap, 1 = one-shot (stop at rollover)
load_val  input  NUM_CH*NUM_CNT_BITS  packed load values; channel i at [i*NUM_CNT_BITS +: NUM_CNT_BITS]
rollover_val  input  NUM_CH*NUM_CNT_BITS  packed rollover values, same packing
count_out  output  NUM_CH*NUM_CNT_BITS  packed registered counts
rollover_flag  output  NUM_CH  per-channel registered flag
any_flag  output  1  OR of all rollover_flag bits (combinational from registers)

Behaviour:
- Reset: clk is the clock; n_rst is the reset, asynchronous and active-low.
  - On reset, all count_out = 0, all rollover_flag = 0, any_flag = 0. With FLEX_CNT_TC_PULSE_EN, tc_pulse = 0.
- All state is registered. Outputs change only on a rising clk edge or on reset assertion.
- Per-channel priority each cycle: clear > load > count_enable > hold.
- Notation: R = rollover_val slice; C = current count; Cn = next count.
- Clear: Cn = 0, flag = 0.
- Load:
  - Cn = load_val.
  - flag = 1 iff load_val == R and R != 0.
  - load_val > R is legal and is handled by the next increment (see below).
- count_enable, R == 0: channel disabled. Cn = C, flag = 0.
- count_enable, wrap mode (one_shot = 0):
  - If C >= R: Cn = 1 (wrap to 1, not 0).
  - Else: Cn = C + 1.
  - flag = (Cn == R).
  - Steady sequence for R = 3: 1,2,3,1,2,3...; flag is high exactly in the cycles where count_out == 3.
- count_enable, one-shot mode (one_shot = 1):
  - If C >= R: Cn = C, flag = 1 (sticky).
  - Else: Cn = C + 1, flag = (Cn == R).
  - Only clear or load restarts the channel.
- Hold (no clear, load or enable): Cn = C, flag holds its registered value.
  - A change of rollover_val or one_shot alone does not update the flag until the next clear, load or enable.
- R == 1, wrap mode: count goes 0 -> 1 with flag = 1, then stays at 1 with flag = 1 while enabled.
- Arithmetic is NUM_CNT_BITS wide, unsigned.
  - C + 1 never overflows, because C < R <= 2^N - 1 whenever it is computed.
- Switching one_shot mid-count takes effect on the next enabled cycle using the current C.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- Latency: control input at edge k -> count_out and rollover_flag updated at edge k (visible after it). any_flag follows in the same cycle.
- n_rst asserted mid-count forces the reset values immediately. After release, the first active edge evaluates normally from count 0.

Optional Feature:
Macro FLEX_CNT_TC_PULSE_EN.
- Defined:
  - Adds output tc_pulse, NUM_CH wide, registered, reset 0.
  - tc_pulse[i] is high for exactly one cycle on each 0->1 transition of rollover_flag[i].
  - A transition caused by load counts.
  - In wrap mode with R == 1, only the first entry pulses.
  - A sticky one-shot flag pulses once.
- Not defined: port and logic absent. All other behaviour is identical.

Test Plan:
1. Reset, then NUM_CNT_BITS=4, ch0 wrap, R=3, enable held for 7 cycles -> count_out 1,2,3,1,2,3,1; flag high only at the two cycles showing 3; any_flag mirrors it.
2. ch1 one-shot, R=5, enable held for 8 cycles -> counts 1..5, then stays 5 with flag = 1; a clear pulse -> count 0, flag 0; re-enable -> 1.
3. ch0 load with load_val=9, R=4, then enable -> count 9, flag 0, then 1 (wrap since 9>=4); load_val=4 with R=4 -> count 4, flag 1 the next cycle.
4. Same-cycle clear+load+enable on ch0 while ch1 enables (R=2) -> ch0 goes to 0 with flag 0; ch1 increments unaffected.
5. R=0 with enable for 4 cycles -> count stays at its value, flag 0; then R=15 and enable to 15 -> flag 1, next enable -> count 1, flag 0.
6. Assert n_rst mid-count (count=2, flag=0), with FLEX_CNT_TC_PULSE_EN defined -> all outputs 0 immediately. After release with R=2, enable x2 -> tc_pulse high for exactly one cycle when count reaches 2.

Source files
------------

// File: rtl/flex_counter_mc.sv
// Multi-channel flexible counter: per-channel clear/load/enable, wrap or one-shot rollover.
// Define FLEX_CNT_TC_PULSE_EN to add the per-channel tc_pulse output.
module flex_counter_mc #(
  parameter int unsigned NUM_CNT_BITS = 4,
  parameter int unsigned NUM_CH       = 2
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              load,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              one_shot,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic                           any_flag
`ifdef FLEX_CNT_TC_PULSE_EN
  ,
  output logic [NUM_CH-1:0]              tc_pulse
`endif
);

  localparam int unsigned N  = NUM_CNT_BITS;
  localparam int unsigned TW = NUM_CH * NUM_CNT_BITS;

  logic [TW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0] flag_q, flag_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [N-1:0] cur, rv, lv, inc, nxt;
    logic         f_nxt;

    assign cur = cnt_q[i*N +: N];
    assign rv  = rollover_val[i*N +: N];
    assign lv  = load_val[i*N +: N];
    assign inc = cur + N'(1);

    // Priority: clear > load > enable > hold; R == 0 disables counting.
    always_comb begin
      nxt   = cur;
      f_nxt = flag_q[i];
      if (clear[i]) begin
        nxt   = '0;
        f_nxt = 1'b0;
      end else if (load[i]) begin
        nxt   = lv;
        f_nxt = (lv == rv) && (rv != '0);
      end else if (count_enable[i]) begin
        if (rv == '0) begin
          nxt   = cur;
          f_nxt = 1'b0;
        end else if (cur >= rv) begin
          nxt   = one_shot[i] ? cur : N'(1);
          f_nxt = one_shot[i] ? 1'b1 : (N'(1) == rv);
        end else begin
          nxt   = inc;
          f_nxt = (inc == rv);
        end
      end
    end

    assign cnt_d[i*N +: N] = nxt;
    assign flag_d[i]       = f_nxt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      flag_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

`ifdef FLEX_CNT_TC_PULSE_EN
  logic [NUM_CH-1:0] pulse_q, pulse_d;

  // One-cycle pulse on each rising edge of a channel's flag.
  assign pulse_d = flag_d & ~flag_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) pulse_q <= '0;
    else        pulse_q <= pulse_d;
  end

  assign tc_pulse = pulse_q;
`endif

  assign count_out     = cnt_q;
  assign rollover_flag = flag_q;
  assign any_flag      = |flag_q;

endmodule
